xor_arbiter: RTL

XOR_ARBITER -- requirements
Module: xor_arbiter

---
 rtl/xor_arbiter_if.sv | 28 ++
 rtl/xor_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/xor_arbiter_if.sv
// Bundle of request/operand/grant signals between requesters, the arbiter and
// the shared registered XOR unit.
interface xor_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       res;
  logic               xu_en;
  logic [W-1:0]       xu_a;
  logic [W-1:0]       xu_b;
  logic [W-1:0]       xu_z;
  logic               busy;

  modport master (
    output req, a_in, b_in, xu_z,
    input  gnt, done, res, xu_en, xu_a, xu_b, busy
  );

  modport slave (
    input  req, a_in, b_in, xu_z,
    output gnt, done, res, xu_en, xu_a, xu_b, busy
  );
endinterface

// File: rtl/xor_arbiter.sv
// Four-requester arbiter sharing one registered XOR unit (IDLE/ISSUE/WAIT/RESP).
// Define XOR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module xor_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  xor_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic             xu_en_q, xu_en_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;

  // Winner search starting at ptr, wrapping at the top index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr_q + PW'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    xu_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = ISSUE;
          gnt_d   = N_REQ'(1) << win;
          opa_d   = bus.a_in[win*W +: W];
          opb_d   = bus.b_in[win*W +: W];
          xu_en_d = 1'b1;
`ifdef XOR_ARB_FIXED_PRIO_EN
          ptr_d   = '0;
`else
          ptr_d   = win + PW'(1);
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        res_d   = bus.xu_z;
        done_d  = gnt_q;
        state_d = RESP;
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      xu_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      xu_en_q <= xu_en_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.res   = res_q;
  assign bus.xu_en = xu_en_q;
  assign bus.xu_a  = opa_q;
  assign bus.xu_b  = opb_q;
  assign bus.busy  = busy_q;
endmodule
